matrix_loader: RTL and testbench

Parametrised successor of the ROM-to-RAM matrix copier. On a `start` pulse it streams `ROWS*COLS` words from a source memory with 1-cycle read latency, starting at a runtime base address. It places each word into an internal `ROWS x COLS` matrix register array in row-major or column-major (transpose) order and signals completion with a `done` pulse. It sits between the ROM/DMA source path and the matrix compute blocks, replacing hard-coded 4x4, fixed-address loading.

---
 rtl/matrix_loader.sv | 178 +++++++++++++++++
 tb/tb_matrix_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// matrix_loader: streams ROWS*COLS source words into a row/column-major matrix.
// Optional running checksum of loaded words under MATRIX_LOADER_CHECKSUM_EN.
module matrix_loader #(
    parameter int DATA_WIDTH     = 8,
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SRC_ADDR_WIDTH = 8,
    localparam int N             = ROWS * COLS,
    localparam int CHK_WIDTH     = DATA_WIDTH + $clog2(N) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      transpose,
    input  logic [SRC_ADDR_WIDTH-1:0] base_addr,
    output logic                      src_rd_en,
    output logic [SRC_ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0]     src_data,
    output logic                      busy,
    output logic                      done,
    output logic [N*DATA_WIDTH-1:0]   matrix_flat,
    output logic [CHK_WIDTH-1:0]      checksum
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_n;

    logic                      start_acc;
    logic                      capture;
    logic                      rd_pending_q;
    logic                      trans_q;
    logic [KW-1:0]             k_q;
    logic [SRC_ADDR_WIDTH-1:0] addr_q;
    logic [RW-1:0]             r_q;
    logic [CW-1:0]             c_q;
    logic [DATA_WIDTH-1:0]     mat_q [ROWS][COLS];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        start_acc = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        src_rd_en = 1'b0;
        src_addr  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_n   = S_LOAD;
                    start_acc = 1'b1;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                src_rd_en = 1'b1;
                src_addr  = addr_q;
                if (abort) begin
                    state_n = S_IDLE;
                end else if (k_q == K_LAST) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy    = 1'b1;
                state_n = abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // An abort in the same cycle drops the word in flight
    assign capture = rd_pending_q && !abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pending_q <= 1'b0;
            trans_q      <= 1'b0;
            k_q          <= '0;
            addr_q       <= '0;
        end else begin
            rd_pending_q <= src_rd_en && !abort;
            if (start_acc) begin
                trans_q <= transpose;
                k_q     <= '0;
                addr_q  <= base_addr;
            end else if (state_q == S_LOAD) begin
                k_q    <= k_q + KW'(1);
                addr_q <= addr_q + SRC_ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
            c_q <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mat_q[r][c] <= '0;
                end
            end
        end else if (start_acc) begin
            r_q <= '0;
            c_q <= '0;
        end else if (capture) begin
            mat_q[r_q][c_q] <= src_data;
            if (!trans_q) begin
                if (c_q == C_LAST) begin
                    c_q <= '0;
                    r_q <= (r_q == R_LAST) ? '0 : r_q + RW'(1);
                end else begin
                    c_q <= c_q + CW'(1);
                end
            end else begin
                if (r_q == R_LAST) begin
                    r_q <= '0;
                    c_q <= (c_q == C_LAST) ? '0 : c_q + CW'(1);
                end else begin
                    r_q <= r_q + RW'(1);
                end
            end
        end
    end

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            assign matrix_flat[(gr*COLS+gc)*DATA_WIDTH +: DATA_WIDTH] = mat_q[gr][gc];
        end
    end

`ifdef MATRIX_LOADER_CHECKSUM_EN
    logic [CHK_WIDTH-1:0] chk_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            chk_q <= '0;
        end else if (start_acc) begin
            chk_q <= '0;
        end else if (capture) begin
            chk_q <= chk_q + CHK_WIDTH'(src_data);
        end
    end

    assign checksum = chk_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader (4x4, 8-bit) with a behavioural
// source memory and a queue-free array model of the loaded matrix.
module tb_matrix_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic         transpose;
    logic [7:0]   base_addr;
    logic         src_rd_en;
    logic [7:0]   src_addr;
    logic [7:0]   src_data;
    logic         busy;
    logic         done;
    logic [127:0] matrix_flat;
    logic [12:0]  checksum;

    matrix_loader dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .transpose(transpose),
        .base_addr(base_addr),
        .src_rd_en(src_rd_en),
        .src_addr(src_addr),
        .src_data(src_data),
        .busy(busy),
        .done(done),
        .matrix_flat(matrix_flat),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    logic [7:0] src_mem [256];

    always @(posedge clk)
        src_data <= src_rd_en ? src_mem[src_addr] : 8'($urandom);

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_mat [16];

    int           done_at, done_cnt, rd_cnt, busy_cnt, rd_after;
    logic [7:0]   addrs [$];
    logic [127:0] snap_mat;
    logic [12:0]  snap_chk;
    logic         post_busy, post_done, post_rd;
    logic [7:0]   post_addr;
    logic [127:0] post_mat;
    logic [12:0]  post_chk;

    function automatic logic [127:0] exp_flat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[i*8 +: 8] = exp_mat[i];
        return f;
    endfunction

    task automatic model_apply(input logic [7:0] b, input logic t, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int idx;
            idx = t ? (i % 4) * 4 + i / 4 : i;
            exp_mat[idx] = src_mem[8'(b + i)];
        end
    endtask

    function automatic logic [12:0] model_chk(input logic [7:0] b);
        int s;
        s = 0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
        for (int i = 0; i < 16; i++) s += src_mem[8'(b + i)];
`endif
        return 13'(s);
    endfunction

    task automatic fill_inc();
        for (int a = 0; a < 256; a++) src_mem[a] = 8'(a + 1);
    endtask

    task automatic fill_rand();
        for (int a = 0; a < 256; a++) src_mem[a] = 8'($urandom);
    endtask

    // Drives one start and observes 40 cycles; evt_at values < 0 disable events
    task automatic run_load(input logic [7:0] b, input logic t,
                            input int abort_at, input int restart_at,
                            input int reset_at);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; transpose = t;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 8'($urandom); transpose = ~t;
        done_at = -1; done_cnt = 0; rd_cnt = 0; busy_cnt = 0; rd_after = 0;
        addrs.delete();
        post_busy = 1'bx;
        for (int i = 0; i < 40; i++) begin
            if (src_rd_en) begin
                rd_cnt++;
                addrs.push_back(src_addr);
                if (abort_at >= 0 && i > abort_at) rd_after++;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = i; snap_mat = matrix_flat; snap_chk = checksum;
                end
            end
            if (i == abort_at) abort = 1'b1;
            if (i == restart_at) start = 1'b1;
            if (i == reset_at) reset = 1'b1;
            @(posedge clk); #1;
            if (i == abort_at || i == reset_at) begin
                post_busy = busy; post_done = done; post_rd = src_rd_en;
                post_addr = src_addr; post_mat = matrix_flat; post_chk = checksum;
            end
            abort = 1'b0; start = 1'b0; reset = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; transpose = 1'b0; base_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 16; i++) exp_mat[i] = '0;
        checks += 6;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        if (src_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", src_rd_en); end
        if (src_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", src_addr); end
        if (matrix_flat !== 128'h0) begin errors++; $display("FAIL reset_matrix: got %h expected 0", matrix_flat); end
        if (checksum !== 13'h0) begin errors++; $display("FAIL reset_checksum: got %h expected 0", checksum); end
    endtask

    task automatic test_row_major();
        logic [12:0] ec;
        fill_inc();
        run_load(8'h00, 1'b0, -1, -1, -1);
        model_apply(8'h00, 1'b0, 16);
`ifdef MATRIX_LOADER_CHECKSUM_EN
        ec = 13'd136;
`else
        ec = 13'd0;
`endif
        checks += 8;
        if (done_at !== 17) begin errors++; $display("FAIL row_done_latency: got %0d expected 17", done_at); end
        if (done_cnt !== 1) begin errors++; $display("FAIL row_done_count: got %0d expected 1", done_cnt); end
        if (rd_cnt !== 16) begin errors++; $display("FAIL row_rd_count: got %0d expected 16", rd_cnt); end
        if (busy_cnt !== 17) begin errors++; $display("FAIL row_busy_count: got %0d expected 17", busy_cnt); end
        if (snap_mat !== exp_flat()) begin errors++; $display("FAIL row_matrix: got %h expected %h", snap_mat, exp_flat()); end
        if (snap_mat[31:0] !== 32'h04030201) begin errors++; $display("FAIL row_row0: got %h expected 04030201", snap_mat[31:0]); end
        if (snap_mat[127:120] !== 8'h10) begin errors++; $display("FAIL row_elem33: got %h expected 10", snap_mat[127:120]); end
        if (snap_chk !== ec) begin errors++; $display("FAIL row_checksum: got %0d expected %0d", snap_chk, ec); end
    endtask

    task automatic test_transpose();
        fill_inc();
        run_load(8'h00, 1'b1, -1, -1, -1);
        model_apply(8'h00, 1'b1, 16);
        checks += 3;
        if (done_at !== 17) begin errors++; $display("FAIL tr_done_latency: got %0d expected 17", done_at); end
        if (snap_mat !== exp_flat()) begin errors++; $display("FAIL tr_matrix: got %h expected %h", snap_mat, exp_flat()); end
        if (snap_mat[31:0] !== 32'h0D090501) begin errors++; $display("FAIL tr_row0: got %h expected 0D090501", snap_mat[31:0]); end
    endtask

    task automatic test_addr_wrap();
        int bad;
        fill_inc();
        run_load(8'hFE, 1'b0, -1, -1, -1);
        model_apply(8'hFE, 1'b0, 16);
        bad = (addrs.size() != 16) ? 1 : 0;
        for (int i = 0; i < addrs.size() && i < 16; i++)
            if (addrs[i] !== 8'(8'hFE + i)) bad++;
        checks += 3;
        if (bad !== 0) begin errors++; $display("FAIL wrap_addr_seq: got %0d bad entries of %0d expected 0", bad, addrs.size()); end
        if (snap_mat[23:0] !== 24'h0100FF) begin errors++; $display("FAIL wrap_elems: got %h expected 0100FF", snap_mat[23:0]); end
        if (snap_mat !== exp_flat()) begin errors++; $display("FAIL wrap_matrix: got %h expected %h", snap_mat, exp_flat()); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            logic [7:0] b;
            logic       t;
            logic [12:0] ec;
            fill_rand();
            b = 8'($urandom);
            t = 1'($urandom);
            run_load(b, t, -1, -1, -1);
            model_apply(b, t, 16);
            ec = model_chk(b);
            checks += 3;
            if (done_at !== 17) begin errors++; $display("FAIL rand%0d_done: got %0d expected 17", n, done_at); end
            if (snap_mat !== exp_flat()) begin errors++; $display("FAIL rand%0d_matrix: got %h expected %h", n, snap_mat, exp_flat()); end
            if (snap_chk !== ec) begin errors++; $display("FAIL rand%0d_checksum: got %0d expected %0d", n, snap_chk, ec); end
        end
    endtask

    task automatic test_abort();
        logic [7:0] b;
        logic       t;
        for (int a = 0; a < 256; a++) src_mem[a] = 8'hAA;
        run_load(8'($urandom), 1'b0, -1, -1, -1);
        for (int i = 0; i < 16; i++) exp_mat[i] = 8'hAA;
        checks += 1;
        if (snap_mat !== exp_flat()) begin errors++; $display("FAIL abort_prefill: got %h expected %h", snap_mat, exp_flat()); end
        fill_rand();
        b = 8'($urandom);
        t = 1'($urandom);
        run_load(b, t, 5, -1, -1);
        model_apply(b, t, 4);
        checks += 4;
        if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
        if (post_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", post_busy); end
        if (rd_after !== 0) begin errors++; $display("FAIL abort_rd_after: got %0d expected 0", rd_after); end
        if (matrix_flat !== exp_flat()) begin errors++; $display("FAIL abort_matrix: got %h expected %h", matrix_flat, exp_flat()); end
    endtask

    task automatic test_start_while_busy();
        logic [7:0] b;
        fill_rand();
        b = 8'($urandom);
        run_load(b, 1'b0, -1, 3, -1);
        model_apply(b, 1'b0, 16);
        checks += 4;
        if (done_at !== 17) begin errors++; $display("FAIL restart_done: got %0d expected 17", done_at); end
        if (done_cnt !== 1) begin errors++; $display("FAIL restart_done_count: got %0d expected 1", done_cnt); end
        if (rd_cnt !== 16) begin errors++; $display("FAIL restart_rd_count: got %0d expected 16", rd_cnt); end
        if (snap_mat !== exp_flat()) begin errors++; $display("FAIL restart_matrix: got %h expected %h", snap_mat, exp_flat()); end
    endtask

    task automatic test_start_with_abort();
        int act;
        act = 0;
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; base_addr = 8'($urandom);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy || src_rd_en || done) act++;
            @(posedge clk); #1;
        end
        checks += 2;
        if (act !== 0) begin errors++; $display("FAIL start_abort_ignored: got %0d active cycles expected 0", act); end
        if (matrix_flat !== exp_flat()) begin errors++; $display("FAIL start_abort_matrix: got %h expected %h", matrix_flat, exp_flat()); end
    endtask

    task automatic test_reset_mid_load();
        fill_rand();
        run_load(8'($urandom), 1'($urandom), -1, -1, 7);
        for (int i = 0; i < 16; i++) exp_mat[i] = '0;
        checks += 6;
        if (post_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", post_busy); end
        if (post_rd !== 1'b0) begin errors++; $display("FAIL rst_mid_rd_en: got %b expected 0", post_rd); end
        if (post_addr !== 8'h00) begin errors++; $display("FAIL rst_mid_addr: got %h expected 00", post_addr); end
        if (post_mat !== 128'h0) begin errors++; $display("FAIL rst_mid_matrix: got %h expected 0", post_mat); end
        if (post_chk !== 13'h0) begin errors++; $display("FAIL rst_mid_checksum: got %h expected 0", post_chk); end
        if (done_cnt !== 0 || post_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %0d pulses expected 0", done_cnt); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 2; n++) begin
            logic [7:0] b;
            logic       t;
            fill_rand();
            b = 8'($urandom);
            t = 1'(n);
            run_load(b, t, -1, -1, -1);
            model_apply(b, t, 16);
            checks += 2;
            if (done_at !== 17) begin errors++; $display("FAIL b2b%0d_done: got %0d expected 17", n, done_at); end
            if (snap_mat !== exp_flat()) begin errors++; $display("FAIL b2b%0d_matrix: got %h expected %h", n, snap_mat, exp_flat()); end
        end
    endtask

    initial begin
        test_reset();
        test_row_major();
        test_transpose();
        test_addr_wrap();
        test_random();
        test_abort();
        test_start_while_busy();
        test_start_with_abort();
        test_reset_mid_load();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
